cpu_out_capture: RTL
====================

# cpu_out_capture

Synthesizable capture unit for the CPU output port. It samples `out` whenever `outFlag` is high, stores the accepted words in an on-chip circular buffer, and stops after a programmable number of samples. A valid/ready port drains the stored words. Typical uses are on-board result logging and bench-independent checking of CPU output streams.

## Interface
- `DATA_W`, 25: width of the CPU output word.
- `DEPTH`, 16: buffer entries; must be a power of two and at least 2.
- `CNT_W`, 16: width of the stop count and the captured-sample counter.
- `TS_W`, 16: timestamp width; used only with `CPU_OUT_CAPTURE_TS_EN`.

Ports:
- `clock` in 1: single clock; all logic on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `arm` in 1: single-cycle pulse that flushes the buffer, clears counters and starts capture.
- `stop_count` in CNT_W: samples to accept before stopping; 0 means unlimited. Latched on `arm`.
- `outFlag` in 1: CPU output strobe.
- `out` in DATA_W: CPU output word, qualified by `outFlag`.
- `rd_valid` out 1: buffer non-empty; `rd_data` is valid.
- `rd_ready` in 1: consumer accepts the head word.
- `rd_data` out DATA_W (DATA_W+TS_W with the macro): head-of-buffer word, show-ahead.
- `captured` out CNT_W: accepted-sample count since the last `arm`.
- `fill` out $clog2(DEPTH+1): current occupancy.
- `capturing` out 1: state is CAPTURE.
- `done` out 1: stop count reached; sticky until the next `arm`.
- `overflow` out 1: sticky; a sample was dropped because the buffer was full.

## Operation
- States are IDLE, CAPTURE and DONE. The reset state is IDLE.
- `arm` in any state:
  - flushes the buffer (fill=0, pointers=0);
  - clears `captured`, `done` and `overflow`;
  - latches `stop_count`;
  - goes to CAPTURE.
- A sample on the same edge as `arm` is not captured.
- In CAPTURE, a sample is accepted when `outFlag`=1 and either fill<DEPTH, or fill==DEPTH with a pop in the same cycle.
- An accepted sample writes `out` at the write pointer and increments the pointer (mod DEPTH), `fill` and `captured`.
- A sample arriving with a full buffer and no pop is dropped. It sets `overflow` and does not increment `captured`.
- CAPTURE to DONE: on the edge that accepts a sample making `captured`==latched stop_count, when that count is non-zero. `done` is set on the same edge.
- With stop_count 0, the block stays in CAPTURE until the next `arm` or reset. `captured` saturates at all-ones.
- In IDLE and DONE, `outFlag` is ignored; `overflow` and `captured` do not change.
- Readout works in every state:
  - pop when `rd_valid`&&`rd_ready`; this increments the read pointer (mod DEPTH) and decrements `fill`;
  - `rd_ready` while empty has no effect.
- A simultaneous accept and pop leaves `fill` unchanged.
- Pointers wrap silently. Empty/full are derived from `fill`.

## Timing
- After reset, every output is 0: `rd_valid`, `rd_data`, `captured`, `fill`, `capturing`, `done`, `overflow`.
- Write latency is one edge. A sample accepted at edge N:
  - appears in `fill`/`captured` after N;
  - is at the head with `rd_valid`=1 after N if the buffer was empty.
- `rd_data` is registered, or read asynchronously from memory with a registered pointer. It always reflects the current head, with no extra read bubble.
- Back-to-back `outFlag` every cycle is sustained with no gaps.
- `done` rises on the edge that accepts the final sample. `capturing` falls on the same edge.
- `reset` mid-capture aborts immediately. Buffer contents are lost and outputs return to 0 asynchronously.

## Configuration
- `CPU_OUT_CAPTURE_TS_EN` defined:
  - a TS_W free-running cycle counter is cleared on `arm` and increments every cycle;
  - each accepted sample stores {timestamp, out};
  - `rd_data` is DATA_W+TS_W wide, with the timestamp in the upper bits;
  - the counter wraps silently.
- Not defined: no counter. `rd_data` is DATA_W wide and holds `out` only.

## Test plan
- Reset sequence with `reset`=1 for two edges → all outputs 0, `capturing`=0, `rd_valid`=0.
- Arm with stop_count=3, then `outFlag` pulses carrying 'h1, 'h2, 'h3, 'h4 → `captured`=3 and `done`=1 after the third pulse; 'h4 ignored; reads return 'h1, 'h2, 'h3, then `rd_valid`=0.
- DEPTH=4, stop_count=0, `rd_ready`=0, six consecutive flags carrying 'hA..'hF → `fill`=4, `captured`=4, `overflow`=1; reads return 'hA..'hD.
- Full buffer with `outFlag` and `rd_ready` in the same cycle → `fill` stays 4, `overflow` stays 0, oldest word popped, new word appended.
- Re-arm mid-capture after 2 samples (stop_count=5) → `fill`=0, `captured`=0, `done`=0; next 5 samples are captured and `done`=1.
- With `CPU_OUT_CAPTURE_TS_EN`, arm then `outFlag` on cycles 3 and 7 → stored timestamps 2 and 6 (counter 0 on the first edge after `arm`).

Source files
------------

// File: rtl/cpu_out_capture.sv
// Capture unit for the CPU output port: samples `out` on `outFlag` into a circular buffer drained by valid/ready.
// Define CPU_OUT_CAPTURE_TS_EN to store a per-sample timestamp in the upper bits of each entry.
module cpu_out_capture #(
    parameter int DATA_W = 25,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 16,
    parameter int TS_W   = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        arm,
    input  logic [CNT_W-1:0]            stop_count,
    input  logic                        outFlag,
    input  logic [DATA_W-1:0]           out,
    output logic                        rd_valid,
    input  logic                        rd_ready,
`ifdef CPU_OUT_CAPTURE_TS_EN
    output logic [DATA_W+TS_W-1:0]      rd_data,
`else
    output logic [DATA_W-1:0]           rd_data,
`endif
    output logic [CNT_W-1:0]            captured,
    output logic [$clog2(DEPTH+1)-1:0]  fill,
    output logic                        capturing,
    output logic                        done,
    output logic                        overflow
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int FILL_W = $clog2(DEPTH+1);
    localparam logic [FILL_W-1:0] FULL = FILL_W'(DEPTH);
`ifdef CPU_OUT_CAPTURE_TS_EN
    localparam int ENT_W = DATA_W + TS_W;
`else
    localparam int ENT_W = DATA_W;
`endif

    typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

    state_t              state, state_nxt;
    logic [ENT_W-1:0]    mem [DEPTH];
    logic [ENT_W-1:0]    wdata;
    logic [PTR_W-1:0]    wptr, rptr;
    logic [CNT_W-1:0]    stop_lat;
    logic                pop, sample, accept, drop, hit_stop;

    // Sample counter holds at all-ones instead of wrapping in unlimited mode.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign rd_valid  = (fill != '0);
    assign pop       = rd_valid && rd_ready;
    assign sample    = (state == CAPTURE) && outFlag && !arm;
    assign accept    = sample && ((fill != FULL) || pop);
    assign drop      = sample && (fill == FULL) && !pop;
    assign hit_stop  = accept && (stop_lat != '0) && (captured == stop_lat - 1'b1);
    assign capturing = (state == CAPTURE);
    assign done      = (state == DONE);

`ifdef CPU_OUT_CAPTURE_TS_EN
    logic [TS_W-1:0] ts;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)    ts <= '0;
        else if (arm) ts <= '0;
        else          ts <= ts + 1'b1;
    end

    assign wdata = {ts, out};
`else
    assign wdata = out;
`endif

    always_comb begin
        state_nxt = state;
        if (arm)
            state_nxt = CAPTURE;
        else if ((state == CAPTURE) && hit_stop)
            state_nxt = DONE;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            wptr     <= '0;
            rptr     <= '0;
            fill     <= '0;
            captured <= '0;
            stop_lat <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            if (arm) begin
                wptr     <= '0;
                rptr     <= '0;
                fill     <= '0;
                captured <= '0;
                stop_lat <= stop_count;
                overflow <= 1'b0;
            end else begin
                if (accept) begin
                    wptr     <= wptr + 1'b1;
                    captured <= sat_inc(captured);
                end
                if (pop)
                    rptr <= rptr + 1'b1;
                if (accept && !pop)
                    fill <= fill + 1'b1;
                else if (pop && !accept)
                    fill <= fill - 1'b1;
                if (drop)
                    overflow <= 1'b1;
            end
        end
    end

    // Storage carries no reset; the empty case forces rd_data to zero instead.
    always_ff @(posedge clock) begin
        if (accept)
            mem[wptr] <= wdata;
    end

    assign rd_data = rd_valid ? mem[rptr] : '0;

endmodule
